// File: rtl/instr_mem_param.sv
// Parametrised instruction memory: runtime program load, tracked program length,
// configurable read latency with valid pulse, and NOP/fault on out-of-range fetches.
module instr_mem_param #(
   parameter int unsigned          ADDR_W       = 8,
   parameter int unsigned          DATA_W       = 32,
   parameter int unsigned          DEPTH        = 256,
   parameter int unsigned          READ_LATENCY = 1,
   parameter logic [2:0]           FETCH_STATE  = 3'd0,
   parameter logic [DATA_W-1:0]    NOP_WORD     = '0,
   parameter int unsigned          INIT_LEN     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        state,
   input  logic [ADDR_W-1:0] pc,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] instruction,
   output logic              instr_valid,
   output logic              pc_fault,
   output logic              load_err,
   output logic [ADDR_W:0]   prog_len
);
   localparam int unsigned PW = ADDR_W + 1;
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PW-1:0]     prog_len_q, prog_len_d;
   logic [DATA_W-1:0] instr_q;
   logic              vld_q, fault_q, load_err_q;

   logic [PW-1:0]     pc_ext, la_ext, la_inc;
   logic              fetch, fault_c, load_ok, load_bad;
   logic [DATA_W-1:0] rd_data;
   logic              c_vld, c_flt;
   logic [DATA_W-1:0] c_dat;

   assign pc_ext = {1'b0, pc};
   assign la_ext = {1'b0, load_addr};
   assign la_inc = la_ext + PW'(1);

   assign fetch    = !rst && (state == FETCH_STATE);
   // Range check uses the length held before this edge, so a word loaded now is not yet fetchable.
   assign fault_c  = (pc_ext >= PW'(DEPTH)) || (pc_ext >= prog_len_q);
   assign rd_data  = fault_c ? NOP_WORD : mem_q[pc[IW-1:0]];
   assign load_ok  = !rst && load_en && (la_ext < PW'(DEPTH));
   assign load_bad = !rst && load_en && !(la_ext < PW'(DEPTH));

   always_comb begin
      prog_len_d = prog_len_q;
      if (load_ok && (la_inc > prog_len_q)) prog_len_d = la_inc;
   end

   // Non-blocking write gives read-before-write against a same-edge fetch.
   always_ff @(posedge clk) begin
      if (load_ok) mem_q[load_addr[IW-1:0]] <= load_data;
   end

   generate
      if (READ_LATENCY <= 1) begin : g_direct
         assign c_vld = fetch;
         assign c_dat = rd_data;
         assign c_flt = fault_c;
      end else begin : g_pipe
         logic [READ_LATENCY-1:1]             vld_pipe;
         logic [READ_LATENCY-1:1]             flt_pipe;
         logic [READ_LATENCY-1:1][DATA_W-1:0] dat_pipe;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_pipe <= '0;
               flt_pipe <= '0;
               dat_pipe <= '0;
            end else begin
               vld_pipe[1] <= fetch;
               flt_pipe[1] <= fault_c;
               dat_pipe[1] <= rd_data;
               for (int k = 2; k < int'(READ_LATENCY); k++) begin
                  vld_pipe[k] <= vld_pipe[k-1];
                  flt_pipe[k] <= flt_pipe[k-1];
                  dat_pipe[k] <= dat_pipe[k-1];
               end
            end
         end

         assign c_vld = vld_pipe[READ_LATENCY-1];
         assign c_dat = dat_pipe[READ_LATENCY-1];
         assign c_flt = flt_pipe[READ_LATENCY-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q    <= '0;
         vld_q      <= 1'b0;
         fault_q    <= 1'b0;
         load_err_q <= 1'b0;
         prog_len_q <= PW'(INIT_LEN);
      end else begin
         vld_q      <= c_vld;
         load_err_q <= load_bad;
         prog_len_q <= prog_len_d;
         if (c_vld) begin
            instr_q <= c_dat;
            fault_q <= c_flt;
         end
      end
   end

   assign instruction = instr_q;
   assign instr_valid = vld_q;
   assign pc_fault    = fault_q;
   assign load_err    = load_err_q;
   assign prog_len    = prog_len_q;
endmodule

// File: tb/tb_instr_mem_param.sv
// Directed bench for instr_mem_param: latency-1 / DEPTH-256 and latency-3 / DEPTH-200
// instances share stimulus; a reference model feeds per-instance expectation queues.
module tb_instr_mem_param;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state;
   logic [7:0]  pc;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;

   logic [31:0] instr1, instr3;
   logic        vld1, vld3, flt1, flt3, le1, le3;
   logic [8:0]  pl1_o, pl3_o;

   always #5 clk = ~clk;

   instr_mem_param #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .READ_LATENCY(1),
                     .FETCH_STATE(3'd0), .NOP_WORD(32'h0), .INIT_LEN(0)) u1 (
      .clk(clk), .rst(rst), .state(state), .pc(pc), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .instruction(instr1),
      .instr_valid(vld1), .pc_fault(flt1), .load_err(le1), .prog_len(pl1_o));

   instr_mem_param #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .READ_LATENCY(3),
                     .FETCH_STATE(3'd0), .NOP_WORD(32'h0), .INIT_LEN(0)) u3 (
      .clk(clk), .rst(rst), .state(state), .pc(pc), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .instruction(instr3),
      .instr_valid(vld3), .pc_fault(flt3), .load_err(le3), .prog_len(pl3_o));

   typedef struct {
      int          due;
      logic [31:0] d;
      logic        f;
   } exp_t;

   exp_t        q1[$], q3[$];
   logic [31:0] mm [256];
   logic [8:0]  m_pl1, m_pl3;
   logic        m_le1, m_le3;
   logic [31:0] h1_d, h3_d;
   logic        h1_f, h3_f;
   int          edge_n = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic [2:0] s, input logic [7:0] p,
                       input logic le, input logic [7:0] la, input logic [31:0] ld);
      exp_t e;
      logic [8:0] inc;
      rst = r; state = s; pc = p; load_en = le; load_addr = la; load_data = ld;
      m_le1 = 1'b0; m_le3 = 1'b0;
      if (r) begin
         q1.delete(); q3.delete();
         m_pl1 = 9'd0; m_pl3 = 9'd0;
         h1_d = '0; h1_f = 1'b0; h3_d = '0; h3_f = 1'b0;
      end else begin
         if (s == 3'd0) begin
            e.due = edge_n;
            e.f   = ({1'b0, p} >= 9'd256) || ({1'b0, p} >= m_pl1);
            e.d   = e.f ? 32'h0 : mm[p];
            q1.push_back(e);
            e.due = edge_n + 2;
            e.f   = ({1'b0, p} >= 9'd200) || ({1'b0, p} >= m_pl3);
            e.d   = e.f ? 32'h0 : mm[p];
            q3.push_back(e);
         end
         if (le) begin
            inc = {1'b0, la} + 9'd1;
            if (inc > m_pl1) m_pl1 = inc;
            if ({1'b0, la} < 9'd200) begin
               if (inc > m_pl3) m_pl3 = inc;
            end else m_le3 = 1'b1;
            mm[la] = ld;
         end
      end
      @(posedge clk);
      #1;
      if (q1.size() > 0 && q1[0].due == edge_n) begin
         h1_d = q1[0].d; h1_f = q1[0].f; void'(q1.pop_front());
         chk("u1_valid", 64'(vld1), 64'd1);
      end else chk("u1_valid", 64'(vld1), 64'd0);
      if (q3.size() > 0 && q3[0].due == edge_n) begin
         h3_d = q3[0].d; h3_f = q3[0].f; void'(q3.pop_front());
         chk("u3_valid", 64'(vld3), 64'd1);
      end else chk("u3_valid", 64'(vld3), 64'd0);
      chk("u1_instr",    64'(instr1), 64'(h1_d));
      chk("u1_fault",    64'(flt1),   64'(h1_f));
      chk("u3_instr",    64'(instr3), 64'(h3_d));
      chk("u3_fault",    64'(flt3),   64'(h3_f));
      chk("u1_prog_len", 64'(pl1_o),  64'(m_pl1));
      chk("u3_prog_len", 64'(pl3_o),  64'(m_pl3));
      chk("u1_load_err", 64'(le1),    64'(m_le1));
      chk("u3_load_err", 64'(le3),    64'(m_le3));
      edge_n++;
   endtask

   initial begin
      step(1, 3'd3, 8'd0, 0, 8'd0, 32'h0);
      step(1, 3'd0, 8'd0, 1, 8'd0, 32'h0);
      for (int k = 0; k < 11; k++) step(0, 3'd3, 8'd0, 1, 8'(k), 32'h8C010000 + k);
      step(0, 3'd0, 8'd5, 0, 8'd0, 32'h0);
      for (int k = 0; k < 3; k++) step(0, 3'd3, 8'd9, 0, 8'd0, 32'h0);
      for (int k = 0; k < 3; k++) step(0, 3'd0, 8'(k), 0, 8'd0, 32'h0);
      for (int k = 0; k < 3; k++) step(0, 3'd3, 8'd0, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd11, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd3, 0, 8'd0, 32'h0);
      for (int k = 0; k < 3; k++) step(0, 3'd3, 8'd0, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd11, 1, 8'd11, 32'hDEADBEEF);
      step(0, 3'd0, 8'd11, 0, 8'd0, 32'h0);
      for (int k = 0; k < 3; k++) step(0, 3'd3, 8'd0, 0, 8'd0, 32'h0);
      step(0, 3'd3, 8'd0, 1, 8'd250, 32'h12345678);
      step(0, 3'd0, 8'd250, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd199, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd255, 1, 8'd199, 32'hCAFEF00D);
      for (int k = 0; k < 3; k++) step(0, 3'd3, 8'd0, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd199, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd7, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd8, 0, 8'd0, 32'h0);
      step(1, 3'd0, 8'd9, 1, 8'd20, 32'h0);
      for (int k = 0; k < 4; k++) step(0, 3'd3, 8'd0, 0, 8'd0, 32'h0);
      step(0, 3'd0, 8'd0, 0, 8'd0, 32'h0);
      for (int k = 0; k < 3; k++) step(0, 3'd3, 8'd0, 0, 8'd0, 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
